clk_fwd_gen: RTL

Multi-channel programmable clock generator producing DDR data pairs for output DDR primitives clocked on `clk`/`~clk`. Each channel forwards a divided clock at half-cycle resolution, so output frequency is `2*f_clk/N`. The block sits between the top-level control logic and the per-pin ODDR2 instances. It supersedes the single fixed pass-through forwarder with per-channel divide, enable and glitch-free runtime reconfiguration.

---
 rtl/clk_fwd_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/clk_fwd_gen.sv
// Multi-channel forwarded-clock generator emitting DDR (d0/d1) pairs at half-cycle resolution.
// Optional phase-alignment input sync_req is compiled in with `define CLK_FWD_GEN_SYNC_EN.
module clk_fwd_gen #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8,
  localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                cfg_en,
`ifdef CLK_FWD_GEN_SYNC_EN
  input  logic                sync_req,
`endif
  output logic [CHANNELS-1:0] ddr_d0,
  output logic [CHANNELS-1:0] ddr_d1,
  output logic [CHANNELS-1:0] chan_active,
  output logic [CHANNELS-1:0] cfg_pending
);

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W:0]   ONE_W   = (DIV_W+1)'(1);
  localparam logic [DIV_W:0]   TWO_W   = (DIV_W+1)'(2);

  logic [DIV_W-1:0] cfg_div_clamped;
  logic             sync_now;

  assign cfg_div_clamped = (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;

`ifdef CLK_FWD_GEN_SYNC_EN
  assign sync_now = sync_req;
`else
  assign sync_now = 1'b0;
`endif

  // Out-of-range channel numbers read as ready; the transfer then matches no channel.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHAN_W'(i)) cfg_ready = ~cfg_pending[i];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pdiv_q;
    logic             en_q;
    logic             pen_q;
    logic             pend_q;
    logic [DIV_W:0]   p_q;
    logic [DIV_W:0]   n_w;
    logic [DIV_W:0]   half;
    logic [DIV_W:0]   p1;
    logic [DIV_W:0]   p2;
    logic [DIV_W:0]   p_adv;
    logic             boundary;
    logic             wr;
    logic             apply;
    logic             d0_q;
    logic             d1_q;
    logic             act_q;

    // Positions are one bit wider than N so p+2 cannot wrap at N = 2^DIV_W-1.
    always_comb begin
      n_w      = {1'b0, div_q};
      half     = (n_w + ONE_W) >> 1;
      p1       = p_q + ONE_W;
      if (p1 == n_w) p1 = '0;
      p2       = p_q + TWO_W;
      boundary = (p2 == n_w);
      p_adv    = (p2 < n_w) ? p2 : p2 - n_w;
    end

    assign wr    = cfg_valid & cfg_ready & (cfg_chan == CHAN_W'(g));
    assign apply = pend_q & (~en_q | boundary | sync_now);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        div_q  <= DIV_MIN;
        pdiv_q <= DIV_MIN;
        en_q   <= 1'b0;
        pen_q  <= 1'b0;
        pend_q <= 1'b0;
        p_q    <= '0;
        d0_q   <= 1'b0;
        d1_q   <= 1'b0;
        act_q  <= 1'b0;
      end else begin
        d0_q  <= en_q & (p_q < half);
        d1_q  <= en_q & (p1 < half);
        act_q <= en_q;
        if (apply) begin
          div_q  <= pdiv_q;
          en_q   <= pen_q;
          p_q    <= '0;
          pend_q <= 1'b0;
        end else if (en_q && !sync_now) begin
          p_q <= p_adv;
        end else begin
          p_q <= '0;
        end
        // wr needs cfg_ready, so it never coincides with apply on this channel.
        if (wr) begin
          pdiv_q <= cfg_div_clamped;
          pen_q  <= cfg_en;
          pend_q <= 1'b1;
        end
      end
    end

    assign ddr_d0[g]      = d0_q;
    assign ddr_d1[g]      = d1_q;
    assign chan_active[g] = act_q;
    assign cfg_pending[g] = pend_q;
  end

endmodule
